// File: rtl/store_agu_pkg.sv
// Shared types and helpers for the splitting store AGU.
// Optional forwarding build: STORE_AGU_ZCFWD_EN.
package store_agu_pkg;

  localparam int SQN_W_DEFAULT = 7;
  localparam int TAG_W_DEFAULT = 7;

  typedef enum logic [2:0] {
    SZ_BYTE      = 3'd0,
    SZ_HALF      = 3'd1,
    SZ_WORD      = 3'd2,
    SZ_DWORD     = 3'd3,
    SZ_CBO_CLEAN = 3'd4,
    SZ_CBO_INVAL = 3'd5,
    SZ_CBO_FLUSH = 3'd6,
    SZ_ZCADD     = 3'd7
  } size_e;

  typedef enum logic [1:0] {
    CMO_NONE  = 2'd0,
    CMO_CLEAN = 2'd1,
    CMO_INVAL = 2'd2,
    CMO_FLUSH = 2'd3
  } cmo_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_e;

  // True when a is strictly younger than b, using a w-bit wrapping difference.
  function automatic logic age_younger(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned w);
    logic [31:0] diff;
    logic [31:0] lowMask;
    lowMask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    diff    = (a - b) & lowMask;
    return (diff != '0) && !diff[w-1];
  endfunction

endpackage

// File: rtl/store_agu_lane.sv
// Combinational address/mask/lane-shift datapath with boundary-split detection.
// With STORE_AGU_ZCFWD_EN, size code 7 stores data + sext(imm).
module store_agu_lane
  import store_agu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
) (
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [2:0]        size_i,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN/8-1:0] maskLo_o,
  output logic [XLEN/8-1:0] maskHi_o,
  output logic [XLEN-1:0]   wdataLo_o,
  output logic [XLEN-1:0]   wdataHi_o,
  output logic [1:0]        cmo_o,
  output logic              split_o,
  output logic              except_o
`ifdef STORE_AGU_ZCFWD_EN
  ,
  output logic [XLEN-1:0]   zcSum_o
`endif
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [XLEN-1:0]   immExt;
  logic [XLEN-1:0]   ea;
  logic [XLEN-1:0]   storeData;
  logic [OFFW-1:0]   off;
  logic [1:0]        sizeLog;
  logic              isCbo;
  logic [2*NB-1:0]   baseMask;
  logic [2*NB-1:0]   mFull;
  logic [2*XLEN-1:0] shifted;

  assign immExt = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign ea     = base_i + immExt;
  assign off    = ea[OFFW-1:0];

`ifdef STORE_AGU_ZCFWD_EN
  assign zcSum_o   = data_i + immExt;
  assign storeData = (size_i == SZ_ZCADD) ? zcSum_o : data_i;
`else
  assign storeData = data_i;
`endif

  // Dword only exists on 64-bit datapaths; everything unknown behaves as a word.
  always_comb begin
    sizeLog = 2'd2;
    isCbo   = 1'b0;
    cmo_o   = CMO_NONE;
    case (size_i)
      SZ_BYTE:      sizeLog = 2'd0;
      SZ_HALF:      sizeLog = 2'd1;
      SZ_WORD:      sizeLog = 2'd2;
      SZ_DWORD:     sizeLog = (XLEN == 64) ? 2'd3 : 2'd2;
      SZ_CBO_CLEAN: begin isCbo = 1'b1; cmo_o = CMO_CLEAN; end
      SZ_CBO_INVAL: begin isCbo = 1'b1; cmo_o = CMO_INVAL; end
      SZ_CBO_FLUSH: begin isCbo = 1'b1; cmo_o = CMO_FLUSH; end
      default:      sizeLog = 2'd2;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2*NB; i++) begin
      baseMask[i] = (i < (1 << sizeLog));
    end
  end

  // Double-width shifts give the low-op and high-op lanes in one step.
  assign mFull   = baseMask << off;
  assign shifted = {{XLEN{1'b0}}, storeData} << {off, 3'b000};

  assign addr_o    = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign maskLo_o  = isCbo ? '0 : mFull[NB-1:0];
  assign maskHi_o  = isCbo ? '0 : mFull[2*NB-1:NB];
  assign wdataLo_o = shifted[XLEN-1:0];
  assign wdataHi_o = shifted[2*XLEN-1:XLEN];
  assign split_o   = (maskHi_o != '0);
  assign except_o  = (ea == '0) || (isCbo && (off != '0));

endmodule

// File: rtl/store_agu_split.sv
// Store AGU that splits boundary-crossing stores into two ordered store-queue ops.
// Optional zero-cycle forwarding ports: STORE_AGU_ZCFWD_EN.
module store_agu_split
  import store_agu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12,
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int SQN_W = SQN_W_DEFAULT,
  parameter int RD_W  = 5,
  parameter int STQ_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_valid,
  output logic              OUT_ready,
  input  logic [XLEN-1:0]   IN_base,
  input  logic [XLEN-1:0]   IN_data,
  input  logic [IMM_W-1:0]  IN_imm,
  input  logic [2:0]        IN_size,
  input  logic [TAG_W-1:0]  IN_tag,
  input  logic [SQN_W-1:0]  IN_sqN,
  input  logic [STQ_W-1:0]  IN_stqIdx,
  input  logic              IN_stall,
  input  logic              IN_brValid,
  input  logic [SQN_W-1:0]  IN_brSqN,
  output logic              OUT_valid,
  output logic [XLEN-1:0]   OUT_addr,
  output logic [XLEN/8-1:0] OUT_mask,
  output logic [XLEN-1:0]   OUT_wdata,
  output logic [1:0]        OUT_cmo,
  output logic [TAG_W-1:0]  OUT_tag,
  output logic [SQN_W-1:0]  OUT_sqN,
  output logic [STQ_W-1:0]  OUT_stqIdx,
  output logic              OUT_split,
  output logic              OUT_last,
  output logic              OUT_except
`ifdef STORE_AGU_ZCFWD_EN
  ,
  output logic              OUT_zcValid,
  output logic [TAG_W-1:0]  OUT_zcTag,
  output logic [XLEN-1:0]   OUT_zcData
`endif
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] laneAddr, laneWdataLo, laneWdataHi;
  logic [NB-1:0]   laneMaskLo, laneMaskHi;
  logic [1:0]      laneCmo;
  logic            laneSplit, laneExcept;

  state_e state_q, state_d;

  logic             valid_q,  valid_d;
  logic [XLEN-1:0]  addr_q,   addr_d;
  logic [NB-1:0]    mask_q,   mask_d;
  logic [XLEN-1:0]  wdata_q,  wdata_d;
  logic [1:0]       cmo_q,    cmo_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [SQN_W-1:0] sqn_q,    sqn_d;
  logic [STQ_W-1:0] stq_q,    stq_d;
  logic             split_q,  split_d;
  logic             last_q,   last_d;
  logic             except_q, except_d;

  logic [XLEN-1:0]  hiAddr_q,   hiAddr_d;
  logic [NB-1:0]    hiMask_q,   hiMask_d;
  logic [XLEN-1:0]  hiWdata_q,  hiWdata_d;
  logic [TAG_W-1:0] hiTag_q,    hiTag_d;
  logic [SQN_W-1:0] hiSqn_q,    hiSqn_d;
  logic [STQ_W-1:0] hiStq_q,    hiStq_d;
  logic             hiExcept_q, hiExcept_d;

  logic advance, accept, loaded;
  logic inSquash, outSquash, hiSquash;

  store_agu_lane #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_lane (
    .base_i    (IN_base),
    .data_i    (IN_data),
    .imm_i     (IN_imm),
    .size_i    (IN_size),
    .addr_o    (laneAddr),
    .maskLo_o  (laneMaskLo),
    .maskHi_o  (laneMaskHi),
    .wdataLo_o (laneWdataLo),
    .wdataHi_o (laneWdataHi),
    .cmo_o     (laneCmo),
    .split_o   (laneSplit),
    .except_o  (laneExcept)
`ifdef STORE_AGU_ZCFWD_EN
    ,
    .zcSum_o   (OUT_zcData)
`endif
  );

  assign inSquash  = IN_brValid && age_younger(32'(IN_sqN), 32'(IN_brSqN), SQN_W);
  assign outSquash = IN_brValid && age_younger(32'(sqn_q), 32'(IN_brSqN), SQN_W);
  assign hiSquash  = IN_brValid && age_younger(32'(hiSqn_q), 32'(IN_brSqN), SQN_W);

  assign advance   = !(IN_stall && valid_q);
  assign OUT_ready = (state_q == ST_IDLE) && advance;
  assign accept    = IN_valid && OUT_ready && !inSquash;

`ifdef STORE_AGU_ZCFWD_EN
  assign OUT_zcValid = IN_valid && OUT_ready && (IN_size == SZ_ZCADD);
  assign OUT_zcTag   = IN_tag;
`endif

  // A freshly loaded op was already age-checked, so the output squash only
  // applies when the register is holding or idling.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    cmo_d      = cmo_q;
    tag_d      = tag_q;
    sqn_d      = sqn_q;
    stq_d      = stq_q;
    split_d    = split_q;
    last_d     = last_q;
    except_d   = except_q;
    hiAddr_d   = hiAddr_q;
    hiMask_d   = hiMask_q;
    hiWdata_d  = hiWdata_q;
    hiTag_d    = hiTag_q;
    hiSqn_d    = hiSqn_q;
    hiStq_d    = hiStq_q;
    hiExcept_d = hiExcept_q;
    loaded     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          if (accept) begin
            loaded   = 1'b1;
            valid_d  = 1'b1;
            addr_d   = laneAddr;
            mask_d   = laneMaskLo;
            wdata_d  = laneWdataLo;
            cmo_d    = laneCmo;
            tag_d    = IN_tag;
            sqn_d    = IN_sqN;
            stq_d    = IN_stqIdx;
            split_d  = laneSplit;
            last_d   = !laneSplit;
            except_d = laneExcept;
            if (laneSplit) begin
              state_d    = ST_HI;
              hiAddr_d   = laneAddr + XLEN'(NB);
              hiMask_d   = laneMaskHi;
              hiWdata_d  = laneWdataHi;
              hiTag_d    = IN_tag;
              hiSqn_d    = IN_sqN;
              hiStq_d    = IN_stqIdx + STQ_W'(1);
              hiExcept_d = laneExcept;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      ST_HI: begin
        if (hiSquash) begin
          state_d = ST_IDLE;
        end else if (advance) begin
          loaded   = 1'b1;
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          addr_d   = hiAddr_q;
          mask_d   = hiMask_q;
          wdata_d  = hiWdata_q;
          cmo_d    = CMO_NONE;
          tag_d    = hiTag_q;
          sqn_d    = hiSqn_q;
          stq_d    = hiStq_q;
          split_d  = 1'b1;
          last_d   = 1'b1;
          except_d = hiExcept_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!loaded && outSquash) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      cmo_q      <= '0;
      tag_q      <= '0;
      sqn_q      <= '0;
      stq_q      <= '0;
      split_q    <= 1'b0;
      last_q     <= 1'b0;
      except_q   <= 1'b0;
      hiAddr_q   <= '0;
      hiMask_q   <= '0;
      hiWdata_q  <= '0;
      hiTag_q    <= '0;
      hiSqn_q    <= '0;
      hiStq_q    <= '0;
      hiExcept_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      cmo_q      <= cmo_d;
      tag_q      <= tag_d;
      sqn_q      <= sqn_d;
      stq_q      <= stq_d;
      split_q    <= split_d;
      last_q     <= last_d;
      except_q   <= except_d;
      hiAddr_q   <= hiAddr_d;
      hiMask_q   <= hiMask_d;
      hiWdata_q  <= hiWdata_d;
      hiTag_q    <= hiTag_d;
      hiSqn_q    <= hiSqn_d;
      hiStq_q    <= hiStq_d;
      hiExcept_q <= hiExcept_d;
    end
  end

  assign OUT_valid  = valid_q;
  assign OUT_addr   = addr_q;
  assign OUT_mask   = mask_q;
  assign OUT_wdata  = wdata_q;
  assign OUT_cmo    = cmo_q;
  assign OUT_tag    = tag_q;
  assign OUT_sqN    = sqn_q;
  assign OUT_stqIdx = stq_q;
  assign OUT_split  = split_q;
  assign OUT_last   = last_q;
  assign OUT_except = except_q;

endmodule
